btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
- REQ-001: Parameter STABLE_CYCLES, default 4: consecutive synchronized cycles a new input level must hold before it is accepted; legal range 2..65535.
- REQ-002: clk  input  1  single system clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- REQ-004: btn_raw  input  1  asynchronous, bouncy push-button pin.
- REQ-005: BTN  output  1  debounced, registered button level; drives BTN of the downstream button register.
- REQ-006: press  output  1  one-cycle pulse when BTN goes 0->1.
- REQ-007: release  output  1  one-cycle pulse when BTN goes 1->0.
- REQ-008: state  output  2  current FSM state code, for debug and bench checks.

Function
- REQ-009: btn_raw SHALL pass through a two-flop synchronizer (s1, s2); only s2 feeds the FSM.
- REQ-010: FSM states and codes SHALL be: LOW=00, RISE_CHK=01, HIGH=10, FALL_CHK=11.
- REQ-011: A 16-bit counter cnt SHALL count consecutive cycles of s2 mismatching BTN; it SHALL saturate, never wrap.
- REQ-012: LOW: s2=1 -> RISE_CHK with cnt=1; otherwise stay, cnt=0.
- REQ-013: RISE_CHK: s2=0 -> LOW, cnt=0 (glitch rejected); s2=1 and cnt<STABLE_CYCLES-1 -> stay, cnt+1; s2=1 and cnt=STABLE_CYCLES-1 -> HIGH, cnt=0, BTN<=1, press<=1.
- REQ-014: HIGH: s2=0 -> FALL_CHK with cnt=1; otherwise stay, cnt=0.
- REQ-015: FALL_CHK: s2=1 -> HIGH, cnt=0; s2=0 and cnt<STABLE_CYCLES-1 -> stay, cnt+1; s2=0 and cnt=STABLE_CYCLES-1 -> LOW, cnt=0, BTN<=0, release<=1.
- REQ-016: BTN SHALL be 1 exactly in HIGH and FALL_CHK, registered, never combinational from btn_raw.
- REQ-017: press and release SHALL each be high for exactly one cycle per accepted transition, never both high in one cycle; they SHALL assert on the same edge BTN changes.
- REQ-018: Latency: with edge E1 the first rising edge to sample a new stable btn_raw level, BTN SHALL change on edge E(STABLE_CYCLES+2); 6 edges at default.
- REQ-019: Any s2 pulse shorter than STABLE_CYCLES cycles SHALL leave BTN, press and release unchanged.
- REQ-020: A mismatch interrupted one cycle before acceptance SHALL restart the count from zero on the next mismatch; counts SHALL NOT accumulate across interruptions.
- REQ-021: Illegal state encodings cannot occur with 2 bits; the default branch SHALL go to LOW with cnt=0.

Reset
- REQ-022: rst_n=0 at a rising edge SHALL set s1=0, s2=0, state=LOW, cnt=0, BTN=0, press=0, release=0 on that edge, overriding all other activity.
- REQ-023: Reset asserted in RISE_CHK or FALL_CHK SHALL abort the check with no press/release pulse; after release the FSM SHALL re-qualify from LOW against the current btn_raw.
- REQ-024: Reset asserted while BTN=1 SHALL drop BTN to 0 without a release pulse.
- REQ-025: The first edge with rst_n=1 SHALL be E1 for latency purposes if btn_raw is already 1, so BTN rises on E6 (default).

Verification (STABLE_CYCLES=4)
- REQ-026: Reset 3 cycles, btn_raw=0 -> BTN=0, press=0, release=0, state=00 throughout.
- REQ-027: btn_raw 0->1, held 10 cycles -> BTN=1 from E6; press=1 only during cycle after E6; state 00->01->10.
- REQ-028: Bounce: btn_raw 1,0,1,0 on single cycles, then 1 steady -> no press during bounce; one press exactly 6 edges after the last 0->1; BTN never toggles early.
- REQ-029: From BTN=1, btn_raw=0 held 3 cycles, then 1 -> BTN stays 1, no release, state returns 11->10.
- REQ-030: btn_raw=1 steady, rst_n pulsed low one cycle while state=01 -> BTN=0, no press; BTN=1 on the 6th edge after reset release.
- REQ-031: Full press/release cycle, 20 cycles each level -> exactly one press and one release, BTN matches delayed btn_raw, never both pulses high together.

Source files
------------

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a bouncy push-button and emits a qualified level with press/release pulses
module btn_debounce #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  output logic       BTN,
  output logic       press,
  output logic       released,
  output logic [1:0] state
);
  typedef enum logic [1:0] {LOW = 2'b00, RISE_CHK = 2'b01, HIGH = 2'b10, FALL_CHK = 2'b11} st_t;
  localparam logic [15:0] LAST = 16'(STABLE_CYCLES - 1);
  st_t st, st_nx;
  logic s1, s2, press_nx, rel_nx;
  logic [15:0] cnt, cnt_nx, cnt_inc;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      st <= LOW;
      cnt <= '0;
      press <= 1'b0;
      released <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      st <= st_nx;
      cnt <= cnt_nx;
      press <= press_nx;
      released <= rel_nx;
    end
  end
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  always_comb begin
    st_nx = LOW;
    cnt_nx = '0;
    case (st)
      LOW: begin
        st_nx = s2 ? RISE_CHK : LOW;
        cnt_nx = s2 ? 16'd1 : '0;
      end
      RISE_CHK: begin
        st_nx = !s2 ? LOW : (cnt == LAST) ? HIGH : RISE_CHK;
        cnt_nx = (s2 && cnt != LAST) ? cnt_inc : '0;
      end
      HIGH: begin
        st_nx = !s2 ? FALL_CHK : HIGH;
        cnt_nx = !s2 ? 16'd1 : '0;
      end
      FALL_CHK: begin
        st_nx = s2 ? HIGH : (cnt == LAST) ? LOW : FALL_CHK;
        cnt_nx = (!s2 && cnt != LAST) ? cnt_inc : '0;
      end
      default: begin
        st_nx = LOW;
        cnt_nx = '0;
      end
    endcase
  end
  always_comb begin
    BTN = st[1];
    state = st;
    press_nx = (st == RISE_CHK) && s2 && (cnt == LAST);
    rel_nx = (st == FALL_CHK) && !s2 && (cnt == LAST);
  end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: randomized and directed bench against a run-length reference model
module tb_btn_debounce;
  localparam int S = 4;
  logic clk = 1'b0, rst_n = 1'b0, btn_raw = 1'b0;
  logic BTN, press, released;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  bit m_s1, m_s2, m_db, m_pr, m_rl;
  int m_run;
  btn_debounce #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .BTN(BTN), .press(press), .released(released), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference: the level flips after S consecutive synchronized samples disagree with it.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_pr = 0; m_rl = 0;
    end else begin
      m_pr = 0;
      m_rl = 0;
      m_run = (m_s2 != m_db) ? m_run + 1 : 0;
      if (m_run == S) begin
        m_db = ~m_db;
        m_run = 0;
        m_pr = m_db;
        m_rl = !m_db;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end
  always @(negedge clk) if (chk_en) begin
    check("BTN", 16'(BTN), 16'(m_db));
    check("press", 16'(press), 16'(m_pr));
    check("release", 16'(released), 16'(m_rl));
    check("state", 16'(state), 16'({m_db, m_run != 0}));
  end
  task automatic drive(input bit b, input int n);
    btn_raw = b;
    repeat (n) @(negedge clk);
  endtask
  task automatic latency(input string tag);
    int n;
    n = 0;
    while (!BTN && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 16'(n), 16'(S + 2));
    @(negedge clk);
  endtask
  initial begin
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    btn_raw = 1;
    latency("lat_after_reset");
    drive(1, 6);
    drive(0, 10);
    drive(1, 1); drive(0, 1); drive(1, 1); drive(0, 1);
    drive(1, 12);
    drive(0, 3);
    drive(1, 8);
    check("glitch_kept_high", 16'(BTN), 16'd1);
    drive(0, 10);
    drive(1, 3);
    check("in_rise_chk", 16'(state), 16'b01);
    rst_n = 0;
    @(negedge clk);
    check("reset_abort", 16'(BTN), 16'd0);
    rst_n = 1;
    latency("lat_after_abort");
    drive(1, 5);
    drive(0, 20); drive(1, 20); drive(0, 20);
    repeat (300) begin
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end
      drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
    end
    drive(0, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
